// File: rtl/npu_pkg.sv
// Shared types and defaults for the NPU front end: instruction word, fetch-unit
// state encoding and the default prefetch depth.
package npu_pkg;

    typedef logic [31:0] instruction_t;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_SYNC = 8'h01;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DRAIN  = 3'd2,
        FINISH = 3'd3,
        ABORT  = 3'd4
    } ifu_state_t;

    localparam int IFU_FIFO_DEPTH = 4;

endpackage

// File: rtl/npu_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with flush; simultaneous push and pop
// are accepted at any occupancy, including full.
module npu_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // A push into a full FIFO is only taken when a pop frees the slot this cycle.
    always_comb begin
        do_pop_s  = pop && (count_r != {CNT_W{1'b0}});
        do_push_s = push && ((count_r != CNT_W'(DEPTH)) || do_pop_s);
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (do_push_s && !flush && !rst) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    assign rdata = (count_r == {CNT_W{1'b0}}) ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];
    assign full  = (count_r == CNT_W'(DEPTH));
    assign empty = (count_r == {CNT_W{1'b0}});
    assign count = count_r;

endmodule

// File: rtl/npu_inst_fetch.sv
// Instruction fetch unit: streams a program from instruction memory through a
// credit-limited prefetch FIFO to the NPU controller.
module npu_inst_fetch
    import npu_pkg::*;
#(
    parameter int ADDR_W          = 18,
    parameter int FIFO_DEPTH      = IFU_FIFO_DEPTH,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [15:0]       inst_count,
    output logic              busy,
    output logic              done,
    output logic              resp_error,
    output logic [ADDR_W-1:0] pc_out,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  instruction_t      imem_rdata,
    output instruction_t      instruction,
    output logic              inst_valid,
    input  logic              inst_ready
);

    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    ifu_state_t        state_r, next_state_s;
    logic [ADDR_W-1:0] pc_r;
    logic [15:0]       remaining_issue_r;
    logic [15:0]       remaining_pop_r;
    logic [OUT_W-1:0]  outstanding_r;
    logic              resp_error_r;

    logic [CNT_W-1:0]  fifo_count_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    instruction_t      fifo_rdata_s;
    logic              active_s, launch_s, issue_s, grant_s, ret_s;
    logic              push_s, pop_s, flush_s, issue_last_s, pop_last_s;

    // Request credits use registered counts only, so a pop frees a slot one cycle later.
    always_comb begin
        active_s     = (state_r == FETCH) || (state_r == DRAIN);
        launch_s     = (state_r == IDLE) && start && !abort;
        issue_s      = (state_r == FETCH) && (remaining_issue_r != 16'd0) && !fifo_full_s
                       && ((32'(fifo_count_s) + 32'(outstanding_r)) < 32'(FIFO_DEPTH))
                       && (32'(outstanding_r) < 32'(MAX_OUTSTANDING));
        grant_s      = issue_s && imem_gnt;
        ret_s        = imem_rvalid && (outstanding_r != {OUT_W{1'b0}});
        flush_s      = active_s && abort;
        push_s       = ret_s && active_s && !abort;
        pop_s        = active_s && !fifo_empty_s && inst_ready;
        issue_last_s = (remaining_issue_r == 16'd0) || ((remaining_issue_r == 16'd1) && grant_s);
        pop_last_s   = (remaining_pop_r == 16'd0) || ((remaining_pop_r == 16'd1) && pop_s);
    end

    // Next-state logic. An empty program passes through DRAIN so that done follows busy by a cycle.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (launch_s) begin
                    next_state_s = (inst_count == 16'd0) ? DRAIN : FETCH;
                end else begin
                    next_state_s = IDLE;
                end
            end
            FETCH: begin
                if (abort) begin
                    next_state_s = ABORT;
                end else if (issue_last_s) begin
                    next_state_s = DRAIN;
                end else begin
                    next_state_s = FETCH;
                end
            end
            DRAIN: begin
                if (abort) begin
                    next_state_s = ABORT;
                end else if (pop_last_s) begin
                    next_state_s = FINISH;
                end else begin
                    next_state_s = DRAIN;
                end
            end
            FINISH:  next_state_s = IDLE;
            ABORT: begin
                if (outstanding_r == {OUT_W{1'b0}}) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = ABORT;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // State, program counter, issue/pop counters and the outstanding-read tally.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r           <= IDLE;
            pc_r              <= {ADDR_W{1'b0}};
            remaining_issue_r <= 16'd0;
            remaining_pop_r   <= 16'd0;
            outstanding_r     <= {OUT_W{1'b0}};
            resp_error_r      <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            resp_error_r <= imem_rvalid && (outstanding_r == {OUT_W{1'b0}});
            if (launch_s) begin
                pc_r              <= base_addr;
                remaining_issue_r <= inst_count;
                remaining_pop_r   <= inst_count;
            end else begin
                if (grant_s) begin
                    pc_r              <= pc_r + ADDR_W'(1);
                    remaining_issue_r <= remaining_issue_r - 16'd1;
                end
                if (pop_s && (remaining_pop_r != 16'd0)) begin
                    remaining_pop_r <= remaining_pop_r - 16'd1;
                end
            end
            case ({grant_s, ret_s})
                2'b10:   outstanding_r <= outstanding_r + OUT_W'(1);
                2'b01:   outstanding_r <= outstanding_r - OUT_W'(1);
                default: outstanding_r <= outstanding_r;
            endcase
        end
    end

    npu_sync_fifo #(
        .WIDTH ($bits(instruction_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .flush (flush_s),
        .wdata (imem_rdata),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    assign busy        = (state_r != IDLE);
    assign done        = (state_r == FINISH);
    assign resp_error  = resp_error_r;
    assign pc_out      = pc_r;
    assign imem_req    = issue_s;
    assign imem_addr   = pc_r;
    assign instruction = fifo_rdata_s;
    assign inst_valid  = active_s && !fifo_empty_s;

endmodule

// File: tb/tb_npu_inst_fetch.sv
// Scenario bench for npu_inst_fetch: a latency-configurable memory model feeds the
// DUT, expected instruction words are queued at launch and compared on delivery.
module tb_npu_inst_fetch;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [17:0] base_addr;
    logic [15:0] inst_count;
    logic        busy, done, resp_error;
    logic [17:0] pc_out;
    logic        imem_req;
    logic [17:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic        inst_valid;
    logic        inst_ready;

    npu_inst_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .base_addr   (base_addr),
        .inst_count  (inst_count),
        .busy        (busy),
        .done        (done),
        .resp_error  (resp_error),
        .pc_out      (pc_out),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instruction (instruction),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [17:0] addr;
        int          due;
    } pend_t;

    pend_t       pend_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] obs_inst_q[$];
    logic [17:0] obs_addr_q[$];

    int n_cmp, n_fail;
    int cyc, launch_cyc, lat;
    bit gnt_en, ready_en, inject_rv;
    int done_cnt, done_rel, err_cnt, req_cnt;
    int first_req, first_valid, first_xfer, last_xfer;
    bit busy_tr[64];
    int pend_tr[64];

    function automatic logic [31:0] mem_word(input logic [17:0] a);
        mem_word = {a[7:0] ^ 8'h5A, 6'b101010, a};
    endfunction

    // One clock cycle: drive memory/consumer inputs, record observations, advance.
    task automatic step();
        int rel;
        rel = cyc - launch_cyc;
        if (rel >= 0 && rel < 64) begin
            busy_tr[rel] = busy;
            pend_tr[rel] = pend_q.size();
        end
        if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend_q[0].addr);
            void'(pend_q.pop_front());
        end else if (inject_rv) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hDEAD_BEEF;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
        imem_gnt   = gnt_en;
        inst_ready = ready_en;
        #1;
        if (imem_req && imem_gnt) begin
            obs_addr_q.push_back(imem_addr);
            pend_q.push_back('{addr: imem_addr, due: cyc + lat});
            req_cnt++;
        end
        if (imem_req && first_req < 0) first_req = rel;
        if (inst_valid && first_valid < 0) first_valid = rel;
        if (inst_valid && inst_ready) begin
            obs_inst_q.push_back(instruction);
            if (first_xfer < 0) first_xfer = rel;
            last_xfer = rel;
        end
        if (done) begin
            done_cnt++;
            done_rel = rel;
        end
        if (resp_error) err_cnt++;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic launch(input logic [17:0] b, input logic [15:0] n);
        exp_q.delete();
        obs_inst_q.delete();
        obs_addr_q.delete();
        done_cnt = 0; done_rel = -1; err_cnt = 0; req_cnt = 0;
        first_req = -1; first_valid = -1; first_xfer = -1; last_xfer = -1;
        for (int i = 0; i < 64; i++) begin
            busy_tr[i] = 1'b0;
            pend_tr[i] = 0;
        end
        launch_cyc = cyc;
        for (int i = 0; i < int'(n); i++) exp_q.push_back(mem_word(b + 18'(i)));
        start      = 1'b1;
        base_addr  = b;
        inst_count = n;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_cmp++;
        if ({busy, done, resp_error, imem_req, inst_valid, pc_out, imem_addr, instruction} !== 73'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0",
                     {busy, done, resp_error, imem_req, inst_valid, pc_out, imem_addr, instruction});
        end
        rst = 1'b0;
        step();
        n_cmp++;
        if ({busy, imem_req, inst_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_release_idle: got %b want 000", {busy, imem_req, inst_valid});
        end
    endtask

    task automatic test_basic();
        logic [31:0] e, g;
        gnt_en = 1'b1; ready_en = 1'b1; lat = 1;
        launch(18'h00100, 16'd3);
        repeat (12) step();
        n_cmp++;
        if (obs_addr_q.size() != 3) begin
            n_fail++; $display("FAIL basic_req_count: got %0d want 3", obs_addr_q.size());
        end
        for (int i = 0; i < obs_addr_q.size() && i < 3; i++) begin
            n_cmp++;
            if (obs_addr_q[i] !== 18'h00100 + 18'(i)) begin
                n_fail++; $display("FAIL basic_addr[%0d]: got %h want %h", i, obs_addr_q[i], 18'h00100 + 18'(i));
            end
        end
        n_cmp++;
        if (obs_inst_q.size() != 3) begin
            n_fail++; $display("FAIL basic_deliver_count: got %0d want 3", obs_inst_q.size());
        end
        while (exp_q.size() > 0 && obs_inst_q.size() > 0) begin
            e = exp_q.pop_front(); g = obs_inst_q.pop_front(); n_cmp++;
            if (g !== e) begin n_fail++; $display("FAIL basic_inst: got %h want %h", g, e); end
        end
        n_cmp++;
        if (first_req != 1 || first_valid != 3) begin
            n_fail++; $display("FAIL basic_latency: got req@%0d valid@%0d want req@1 valid@3", first_req, first_valid);
        end
        n_cmp++;
        if (last_xfer - first_xfer != 2) begin
            n_fail++; $display("FAIL basic_throughput: got span %0d want 2", last_xfer - first_xfer);
        end
        n_cmp++;
        if (done_cnt != 1 || done_rel != last_xfer + 1) begin
            n_fail++; $display("FAIL basic_done: got cnt %0d @%0d want 1 @%0d", done_cnt, done_rel, last_xfer + 1);
        end
        n_cmp++;
        if (done_rel < 0 || busy_tr[done_rel] !== 1'b1 || busy_tr[done_rel + 1] !== 1'b0) begin
            n_fail++; $display("FAIL basic_busy_drop: got busy after done %b want 0", busy_tr[done_rel + 1]);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] e, g;
        gnt_en = 1'b1; ready_en = 1'b0; lat = 1;
        launch(18'h00200, 16'd8);
        repeat (12) step();
        n_cmp++;
        if (obs_addr_q.size() != 4 || imem_req !== 1'b0 || inst_valid !== 1'b1) begin
            n_fail++; $display("FAIL bp_credit_stall: got grants %0d req %b valid %b want 4 0 1",
                               obs_addr_q.size(), imem_req, inst_valid);
        end
        ready_en = 1'b1;
        repeat (25) step();
        n_cmp++;
        if (obs_addr_q.size() != 8) begin
            n_fail++; $display("FAIL bp_req_count: got %0d want 8", obs_addr_q.size());
        end
        for (int i = 0; i < obs_addr_q.size() && i < 8; i++) begin
            n_cmp++;
            if (obs_addr_q[i] !== 18'h00200 + 18'(i)) begin
                n_fail++; $display("FAIL bp_addr[%0d]: got %h want %h", i, obs_addr_q[i], 18'h00200 + 18'(i));
            end
        end
        n_cmp++;
        if (obs_inst_q.size() != 8) begin
            n_fail++; $display("FAIL bp_deliver_count: got %0d want 8", obs_inst_q.size());
        end
        while (exp_q.size() > 0 && obs_inst_q.size() > 0) begin
            e = exp_q.pop_front(); g = obs_inst_q.pop_front(); n_cmp++;
            if (g !== e) begin n_fail++; $display("FAIL bp_inst: got %h want %h", g, e); end
        end
        n_cmp++;
        if (done_cnt != 1) begin n_fail++; $display("FAIL bp_done: got %0d want 1", done_cnt); end
    endtask

    task automatic test_empty();
        gnt_en = 1'b1; ready_en = 1'b1; lat = 1;
        launch(18'h00055, 16'd0);
        repeat (5) step();
        n_cmp++;
        if (req_cnt != 0 || first_req != -1) begin
            n_fail++; $display("FAIL empty_no_req: got %0d grants, first req @%0d want none", req_cnt, first_req);
        end
        n_cmp++;
        if (done_cnt != 1 || done_rel != 2) begin
            n_fail++; $display("FAIL empty_done: got cnt %0d @%0d want 1 @2", done_cnt, done_rel);
        end
        n_cmp++;
        if ({busy_tr[0], busy_tr[1], busy_tr[2], busy_tr[3]} !== 4'b0110) begin
            n_fail++; $display("FAIL empty_busy: got %b want 0110", {busy_tr[0], busy_tr[1], busy_tr[2], busy_tr[3]});
        end
    endtask

    task automatic test_wrap();
        logic [31:0] e, g;
        gnt_en = 1'b0; ready_en = 1'b1; lat = 1;
        launch(18'h3FFFF, 16'd2);
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (imem_req !== 1'b1 || imem_addr !== 18'h3FFFF) begin
                n_fail++; $display("FAIL wrap_stall[%0d]: got req %b addr %h want 1 3ffff", k, imem_req, imem_addr);
            end
            step();
        end
        gnt_en = 1'b1;
        step();
        n_cmp++;
        if (imem_addr !== 18'h00000 || pc_out !== 18'h00000 || imem_req !== 1'b1) begin
            n_fail++; $display("FAIL wrap_next_addr: got addr %h pc %h req %b want 0 0 1", imem_addr, pc_out, imem_req);
        end
        repeat (10) step();
        n_cmp++;
        if (obs_inst_q.size() != 2 || done_cnt != 1) begin
            n_fail++; $display("FAIL wrap_deliver: got %0d insts %0d done want 2 1", obs_inst_q.size(), done_cnt);
        end
        while (exp_q.size() > 0 && obs_inst_q.size() > 0) begin
            e = exp_q.pop_front(); g = obs_inst_q.pop_front(); n_cmp++;
            if (g !== e) begin n_fail++; $display("FAIL wrap_inst: got %h want %h", g, e); end
        end
    endtask

    task automatic test_abort();
        logic [31:0] e, g;
        int zero_rel;
        gnt_en = 1'b1; ready_en = 1'b0; lat = 3;
        launch(18'h00040, 16'd3);
        repeat (4) step();
        n_cmp++;
        if (inst_valid !== 1'b1 || pend_q.size() != 2) begin
            n_fail++; $display("FAIL abort_setup: got valid %b pending %0d want 1 2", inst_valid, pend_q.size());
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        n_cmp++;
        if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid_drop: got %b want 0", inst_valid); end
        ready_en = 1'b1;
        repeat (10) step();
        zero_rel = -1;
        for (int r = 6; r < 60 && zero_rel < 0; r++) if (pend_tr[r] == 0) zero_rel = r;
        n_cmp++;
        if (zero_rel < 0 || busy_tr[zero_rel] !== 1'b1 || busy_tr[zero_rel + 1] !== 1'b0) begin
            n_fail++; $display("FAIL abort_busy_drop: got zero@%0d busy %b%b want 10", zero_rel,
                               busy_tr[zero_rel], busy_tr[zero_rel + 1]);
        end
        n_cmp++;
        if (done_cnt != 0 || err_cnt != 0 || obs_inst_q.size() != 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL abort_quiet: got done %0d err %0d delivered %0d busy %b want 0 0 0 0",
                               done_cnt, err_cnt, obs_inst_q.size(), busy);
        end
        lat = 1;
        launch(18'h00080, 16'd2);
        repeat (10) step();
        n_cmp++;
        if (obs_inst_q.size() != 2 || done_cnt != 1 || err_cnt != 0) begin
            n_fail++; $display("FAIL abort_restart: got %0d insts %0d done %0d err want 2 1 0",
                               obs_inst_q.size(), done_cnt, err_cnt);
        end
        while (exp_q.size() > 0 && obs_inst_q.size() > 0) begin
            e = exp_q.pop_front(); g = obs_inst_q.pop_front(); n_cmp++;
            if (g !== e) begin n_fail++; $display("FAIL abort_restart_inst: got %h want %h", g, e); end
        end
    endtask

    task automatic test_errors();
        inject_rv = 1'b1;
        step();
        inject_rv = 1'b0;
        n_cmp++;
        if (resp_error !== 1'b1 || inst_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL err_pulse: got err %b valid %b busy %b want 1 0 0", resp_error, inst_valid, busy);
        end
        step();
        n_cmp++;
        if (resp_error !== 1'b0) begin n_fail++; $display("FAIL err_one_cycle: got %b want 0", resp_error); end
        gnt_en = 1'b1; ready_en = 1'b1; lat = 2;
        launch(18'h00300, 16'd6);
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        pend_q.delete();
        n_cmp++;
        if ({busy, done, resp_error, imem_req, inst_valid, pc_out, imem_addr, instruction} !== 73'd0) begin
            n_fail++; $display("FAIL midrun_reset: got %h want 0",
                               {busy, done, resp_error, imem_req, inst_valid, pc_out, imem_addr, instruction});
        end
        done_cnt = 0;
        repeat (6) step();
        n_cmp++;
        if (done_cnt != 0 || busy !== 1'b0 || imem_req !== 1'b0) begin
            n_fail++; $display("FAIL reset_no_done: got done %0d busy %b req %b want 0 0 0", done_cnt, busy, imem_req);
        end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; cyc = 0; launch_cyc = 0; lat = 1;
        gnt_en = 1'b0; ready_en = 1'b0; inject_rv = 1'b0;
        rst = 1'b1; start = 1'b0; abort = 1'b0; base_addr = 18'h0; inst_count = 16'h0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0; inst_ready = 1'b0;
        done_cnt = 0; done_rel = -1; err_cnt = 0; req_cnt = 0;
        first_req = -1; first_valid = -1; first_xfer = -1; last_xfer = -1;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_backpressure();
        test_empty();
        test_wrap();
        test_abort();
        test_errors();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
